sc_key_capture: RTL and testbench

Memory-mapped key-input responder on the data bus between `sc_cpu` and the on-board `KEY[3:0]` buttons, decoded by `sc_hub`. Synchronizes and debounces the four raw active-low buttons, latches press events in sticky write-1-to-clear flags, counts presses, and raises a maskable interrupt line. Without it, software must poll and debounce the raw KEY pins itself.

---
 rtl/sc_key_capture.sv | 156 +++++++++++++++
 tb/tb_sc_key_capture.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/sc_key_capture.sv
// sc_key_capture: memory-mapped key responder for KEY[3:0].
// Synchronizes and debounces four active-low buttons, latches press events
// in sticky write-1-to-clear flags, counts masked presses and raises a
// maskable interrupt.
//
// Optional feature: define KEYCAP_RELEASE_EN to capture release events in
// EVENT[7:4]. Without it those bits read as 0 and no release logic is built.
//
// Word map: 0 STATUS (lvl), 1 EVENT (W1C), 2 COUNT (any write clears),
//           3 CTRL ([3:0] mask, [4] irq_en).
module sc_key_capture #(
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int CNT_W           = 16
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [3:0]  key_n,
    input  logic        sel,
    input  logic [1:0]  addr,
    input  logic [31:0] wdata,
    input  logic        wmem,
    output logic [31:0] rdata,
    output logic        irq
);

`ifdef KEYCAP_RELEASE_EN
    localparam int EW = 8;
`else
    localparam int EW = 4;
`endif

    localparam logic [CNT_W-1:0] TERM = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [3:0]       sync1;
    logic [3:0]       sync2;
    logic [3:0]       s;
    logic [3:0]       lvl;
    logic [CNT_W-1:0] cnt [4];
    logic [3:0]       toggle;
    logic [3:0]       press;
    logic [3:0]       press_m;
    logic [2:0]       press_pop;
    logic [EW-1:0]    evt;
    logic [EW-1:0]    evt_set;
    logic [15:0]      count;
    logic [3:0]       mask;
    logic             irq_en;
    logic             wr;
    logic             unused_wdata;

    assign unused_wdata = ^wdata[31:5];

    assign wr = sel & wmem;
    assign s  = ~sync2;

    // Two-flop synchronizer per key; reset to released.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync1 <= 4'hF;
            sync2 <= 4'hF;
        end else begin
            sync1 <= key_n;
            sync2 <= sync1;
        end
    end

    // A key's level flips on the edge after its counter has seen
    // DEBOUNCE_CYCLES-1 consecutive differing samples; this edge is also
    // where press/release events are taken so EVENT/COUNT move with lvl.
    always_comb begin
        toggle = '0;
        for (int i = 0; i < 4; i++) begin
            toggle[i] = (s[i] != lvl[i]) && (cnt[i] == TERM);
        end
    end

    assign press     = toggle & ~lvl;
    assign press_m   = press & mask;
    assign press_pop = 3'(press_m[0]) + 3'(press_m[1]) + 3'(press_m[2]) + 3'(press_m[3]);

`ifdef KEYCAP_RELEASE_EN
    assign evt_set = {toggle & lvl & mask, press_m};
    assign irq     = irq_en & |(evt & {mask, mask});
`else
    assign evt_set = press_m;
    assign irq     = irq_en & |(evt & mask);
`endif

    // Per-key debounce counters and debounced levels.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            lvl <= '0;
            for (int i = 0; i < 4; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (s[i] == lvl[i]) begin
                    cnt[i] <= '0;
                end else if (toggle[i]) begin
                    cnt[i] <= '0;
                    lvl[i] <= ~lvl[i];
                end else begin
                    cnt[i] <= cnt[i] + CNT_W'(1);
                end
            end
        end
    end

    // Sticky event flags; a set on the same edge as a clear wins.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            evt <= '0;
        end else if (wr && addr == 2'd1) begin
            evt <= (evt & ~wdata[EW-1:0]) | evt_set;
        end else begin
            evt <= evt | evt_set;
        end
    end

    // Masked press counter; a clearing write still keeps this cycle's presses.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (wr && addr == 2'd2) begin
            count <= 16'(press_pop);
        end else begin
            count <= count + 16'(press_pop);
        end
    end

    // Control register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            mask   <= 4'hF;
            irq_en <= 1'b0;
        end else if (wr && addr == 2'd3) begin
            mask   <= wdata[3:0];
            irq_en <= wdata[4];
        end
    end

    // Combinational read mux; zero when not selected.
    always_comb begin
        rdata = '0;
        if (sel) begin
            case (addr)
                2'd0: rdata[3:0]    = lvl;
                2'd1: rdata[EW-1:0] = evt;
                2'd2: rdata[15:0]   = count;
                default: rdata[4:0] = {irq_en, mask};
            endcase
        end
    end

endmodule

// File: tb/tb_sc_key_capture.sv
module tb_sc_key_capture;

    localparam int D = 4;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [3:0]  key_n = 4'hF;
    logic        sel   = 1'b0;
    logic [1:0]  addr  = 2'd0;
    logic [31:0] wdata = '0;
    logic        wmem  = 1'b0;
    logic [31:0] rdata;
    logic        irq;

    int total  = 0;
    int passed = 0;

    sc_key_capture #(.DEBOUNCE_CYCLES(D), .CNT_W(3)) dut (
        .clock(clock), .reset(reset), .key_n(key_n), .sel(sel), .addr(addr),
        .wdata(wdata), .wmem(wmem), .rdata(rdata), .irq(irq)
    );

    always #5 clock = ~clock;

    // Behavioural model: a key's level flips once the synchronized
    // (two-edge-delayed) pressed samples of the last D edges all disagree
    // with the current level.
    logic [3:0]  samp [0:D];
    logic [3:0]  m_lvl;
    logic [7:0]  m_evt;
    logic [15:0] m_count;
    logic [3:0]  m_mask;
    logic        m_irqen;

    always @(posedge clock or posedge reset) begin
        logic [3:0] tg, pr, rl;
        logic [7:0] setv;
        if (reset) begin
            for (int j = 0; j <= D; j++) samp[j] = 4'h0;
            m_lvl = 0; m_evt = 0; m_count = 0; m_mask = 4'hF; m_irqen = 0;
        end else begin
            tg = 4'hF;
            for (int j = 1; j <= D; j++) tg = tg & (samp[j] ^ m_lvl);
            pr = tg & ~m_lvl;
            rl = tg & m_lvl;
`ifdef KEYCAP_RELEASE_EN
            setv = {rl & m_mask, pr & m_mask};
`else
            setv = {4'h0, pr & m_mask};
`endif
            if (sel && wmem && addr == 2'd1) m_evt = (m_evt & ~wdata[7:0]) | setv;
            else m_evt = m_evt | setv;
            if (sel && wmem && addr == 2'd2) m_count = 16'($countones(pr & m_mask));
            else m_count = m_count + 16'($countones(pr & m_mask));
            if (sel && wmem && addr == 2'd3) {m_irqen, m_mask} = wdata[4:0];
            m_lvl = m_lvl ^ tg;
            for (int j = D; j >= 1; j--) samp[j] = samp[j-1];
            samp[0] = ~key_n;
        end
    end

    function automatic logic [31:0] m_read(input logic [1:0] a);
        case (a)
            2'd0: return {28'h0, m_lvl};
            2'd1: return {24'h0, m_evt};
            2'd2: return {16'h0, m_count};
            default: return {27'h0, m_irqen, m_mask};
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Continuous comparison against the model.
    always @(negedge clock) begin
        if (!reset) begin
            check("model_irq", {31'h0, irq}, {31'h0, m_irqen & |(m_evt & {m_mask, m_mask})});
            if (sel) check("model_rdata", rdata, m_read(addr));
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        sel = 1; wmem = 1; addr = a; wdata = d;
        @(posedge clock);
        #1;
        sel = 0; wmem = 0; wdata = '0;
    endtask

    task automatic rd(input string name, input logic [1:0] a, input logic [31:0] exp);
        sel = 1; addr = a;
        @(negedge clock);
        check(name, rdata, exp);
        #1;
        sel = 0;
    endtask

    initial begin
        tick(2);
        reset = 0;
        tick(1);
        rd("rst_status", 0, 0);
        rd("rst_event", 1, 0);
        rd("rst_count", 2, 0);
        rd("rst_ctrl", 3, 32'hF);
        check("rst_irq", {31'h0, irq}, 0);

        // Clean press on key2: level changes on the sixth edge.
        key_n = 4'b1011;
        tick(5);
        rd("press2_early", 0, 0);
        tick(1);
        rd("press2_status", 0, 4);
        rd("press2_event", 1, 4);
        rd("press2_count", 2, 1);

        // Three-cycle bounce must not flip the level.
        key_n = 4'hF; tick(3);
        key_n = 4'b1011; tick(10);
        rd("bounce_status", 0, 4);
        key_n = 4'hF; tick(6);
        rd("release2_status", 0, 0);
        rd("release2_count", 2, 1);
        wr(1, 4);
        rd("w1c_event", 1, 0);

        // Interrupt on key0, then set-wins against a same-edge clear.
        wr(3, 32'h11);
        key_n = 4'b1110; tick(6);
        rd("irq_event", 1, 1);
        check("irq_high", {31'h0, irq}, 1);
        key_n = 4'hF; tick(6);
        key_n = 4'b1110; tick(5);
        wr(1, 1);
        rd("setwins_event", 1, 1);
        check("setwins_irq", {31'h0, irq}, 1);
        rd("setwins_count", 2, 3);

        // Masked key0 is ignored by EVENT/COUNT but still seen in STATUS.
        wr(3, 32'h1E);
        wr(1, 32'hF);
        key_n = 4'hF; tick(6);
        key_n = 4'b1110; tick(6);
        rd("mask_status", 0, 1);
        rd("mask_event", 1, 0);
        rd("mask_count", 2, 3);
        key_n = 4'b0100; tick(6);
        rd("dual_count", 2, 5);
        rd("dual_event", 1, 32'hA);
        rd("dual_status", 0, 32'hB);
        key_n = 4'hF; tick(6);
        wr(3, 32'hF);
        wr(1, 32'hFF);

        // COUNT wrap and clear-on-press-edge.
        @(negedge clock);
        force dut.count = 16'hFFFF;
        m_count = 16'hFFFF;
        #1;
        release dut.count;
        key_n = 4'b1011; tick(6);
        rd("wrap_count", 2, 0);
        key_n = 4'hF; tick(6);
        key_n = 4'b1011; tick(5);
        wr(2, 32'h1234);
        rd("clr_press_count", 2, 1);
        key_n = 4'hF; tick(6);
        wr(1, 32'hFF);

        // Press and release key1.
        key_n = 4'b1101; tick(6);
        key_n = 4'hF; tick(6);
`ifdef KEYCAP_RELEASE_EN
        rd("release_event", 1, 32'h22);
`else
        rd("release_event", 1, 32'h02);
`endif
        wr(1, 32'hF0);
        rd("upper_w1c_event", 1, 32'h02);

        // Key held through reset is detected again.
        key_n = 4'b0111; tick(3);
        reset = 1; tick(1);
        reset = 0;
        tick(5);
        rd("held_early", 0, 0);
        tick(1);
        rd("held_status", 0, 8);
        rd("held_event", 1, 8);
        rd("held_count", 2, 1);
        key_n = 4'hF; tick(8);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule
